// File: rtl/fifo_unpack_pkg.sv
// Shared definitions for the FIFO unpacker: FSM state encoding, FIFO word
// width, and the index-width helper used by the top and the hold register.
package fifo_unpack_pkg;

    localparam int unsigned FIFO_W = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_POP  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_SEND = 2'd3;

    // Chunk index width; a one-chunk word still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/fifo_unpacker_hold.sv
// unpack_hold: 64-bit load-enable holding register with an indexed chunk mux.
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   load       - capture din on the next rising edge
//   din        - 64-bit word from the FIFO
//   idx        - chunk index selecting the output slice
//   chunk      - hold[idx*OUT_W +: OUT_W], decoded from the register only
module unpack_hold
    import fifo_unpack_pkg::*;
#(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned IDX_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [FIFO_W-1:0] din,
    input  logic [IDX_W-1:0]  idx,
    output logic [OUT_W-1:0]  chunk
);

    localparam int unsigned NCHUNK = FIFO_W / OUT_W;

    logic [FIFO_W-1:0] hold_q;
    logic [FIFO_W-1:0] hold_d;

    // Load-enable next value.
    always_comb begin
        hold_d = hold_q;
        if (load) begin
            hold_d = din;
        end
    end

    // Holding register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Chunk select; a single-chunk word bypasses the mux entirely.
    if (NCHUNK == 1) begin : g_single
        logic unused_idx;
        assign unused_idx = ^idx;
        assign chunk      = hold_q[OUT_W-1:0];
    end else begin : g_multi
        logic [OUT_W-1:0] chunk_arr [NCHUNK];
        for (genvar i = 0; i < int'(NCHUNK); i++) begin : g_slice
            assign chunk_arr[i] = hold_q[i*OUT_W +: OUT_W];
        end
        assign chunk = chunk_arr[idx];
    end

endmodule

// File: rtl/fifo_unpacker.sv
// fifo_unpacker: sole drain of the 64-bit word FIFO. Pops one word, waits for
// it, then streams it out as FIFO_W/OUT_W chunks, LS chunk first, over
// valid/ready.
// Ports:
//   clk, rst         - clock, synchronous active-low reset
//   fifo_empty       - FIFO holds no data
//   pop_fifo         - one-cycle pop request (only from POP)
//   fifo_data        - FIFO output word
//   fifo_data_valid  - fifo_data valid (expected the cycle after pop_fifo)
//   out_data         - current chunk
//   out_valid        - out_data valid, held until accepted
//   out_ready        - consumer accepts when out_valid && out_ready
//   out_last         - current chunk is the final chunk of the word
//   busy             - FSM is not in IDLE
//   err              - sticky: fifo_data_valid seen outside WAIT
module fifo_unpacker
    import fifo_unpack_pkg::*;
#(
    parameter int unsigned OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              pop_fifo,
    input  logic [FIFO_W-1:0] fifo_data,
    input  logic              fifo_data_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam int unsigned   NCHUNK   = FIFO_W / OUT_W;
    localparam int unsigned   IDX_W    = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             err_q;
    logic             err_d;
    logic             load_c;
    logic [OUT_W-1:0] chunk;

    // State, index and error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state, index and capture control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_c  = 1'b0;
        // A word outside WAIT is stray: flag it, otherwise ignore it.
        err_d   = err_q | (fifo_data_valid && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fifo_data_valid) begin
                    load_c  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        pop_fifo  = (state_q == ST_POP);
        out_valid = (state_q == ST_SEND);
        out_last  = (state_q == ST_SEND) && (idx_q == IDX_LAST);
        busy      = (state_q != ST_IDLE);
        err       = err_q;
        out_data  = chunk;
    end

    unpack_hold #(
        .OUT_W (OUT_W),
        .IDX_W (IDX_W)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (load_c),
        .din   (fifo_data),
        .idx   (idx_q),
        .chunk (chunk)
    );

endmodule
